sensor_conditioner: RTL and testbench

//  Upstream stage of the genetic sensor/filter: turns a noisy raw sensor sample into a clean,

---
 rtl/sensor_pkg.sv | 8 +
 rtl/sensor_conditioner_if.sv | 11 +
 rtl/sensor_conditioner_sync2.sv | 28 ++
 rtl/sensor_conditioner.sv | 124 ++++++++++++
 tb/tb_sensor_conditioner.sv | 205 ++++++++++++++++++++
 5 files changed

// File: rtl/sensor_pkg.sv
// Shared types and constants for the sensor conditioning stage.
package sensor_pkg;

    typedef enum logic [2:0] {IDLE, ARMED, ACTIVE, RELEASE, FAULT} cond_state_t;

    localparam int SYNC_STAGES = 2;

endpackage

// File: rtl/sensor_conditioner_if.sv
// Link between the conditioner and the downstream filter.
interface sensor_conditioner_if;

    logic start;
    logic sensor;
    logic actuator_fb;

    modport master (output start, output sensor, input actuator_fb);
    modport slave  (input start, input sensor, output actuator_fb);

endinterface

// File: rtl/sensor_conditioner_sync2.sv
// Multi-flop synchroniser for a single asynchronous bit; resets to 0.
module sync2
    import sensor_pkg::*;
(
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic q
);

    logic [SYNC_STAGES-1:0] sync_q;
    logic [SYNC_STAGES-1:0] sync_d;

    always_comb begin
        sync_d = {sync_q[SYNC_STAGES-2:0], d};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q <= '0;
        end else begin
            sync_q <= sync_d;
        end
    end

    assign q = sync_q[SYNC_STAGES-1];

endmodule

// File: rtl/sensor_conditioner.sv
// Debounces the raw sensor, counts rejected glitches and sequences Start
// against the filter's Actuator feedback, with a response timeout.
module sensor_conditioner
    import sensor_pkg::*;
#(
    parameter int DEBOUNCE = 4,
    parameter int TIMEOUT  = 64,
    parameter int GCNT_W   = 8
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   raw_sensor,
    input  logic                   arm,
    input  logic                   fault_clr,
    sensor_conditioner_if.master   filt,
    output logic                   busy,
    output logic                   fault,
    output logic [GCNT_W-1:0]      glitch_cnt
);

    localparam int DB_W = $clog2(DEBOUNCE + 1);
    localparam int TM_W = $clog2(TIMEOUT);

    logic raw_s;
    logic fb_s;

    sync2 u_sync_raw (.clk(clk), .rst_n(rst_n), .d(raw_sensor),       .q(raw_s));
    sync2 u_sync_fb  (.clk(clk), .rst_n(rst_n), .d(filt.actuator_fb), .q(fb_s));

    logic [DB_W-1:0]   run_q, run_d;
    logic              sensor_q, sensor_d;
    logic [GCNT_W-1:0] glitch_q, glitch_d;

    // A run that ends before reaching DEBOUNCE counts as one rejected glitch.
    always_comb begin
        run_d    = run_q;
        sensor_d = sensor_q;
        glitch_d = glitch_q;
        if (raw_s != sensor_q) begin
            if (run_q == DB_W'(DEBOUNCE - 1)) begin
                sensor_d = ~sensor_q;
                run_d    = '0;
            end else begin
                run_d = run_q + 1'b1;
            end
        end else begin
            run_d = '0;
            if (run_q != '0 && glitch_q != '1) begin
                glitch_d = glitch_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            run_q    <= '0;
            sensor_q <= 1'b0;
            glitch_q <= '0;
        end else begin
            run_q    <= run_d;
            sensor_q <= sensor_d;
            glitch_q <= glitch_d;
        end
    end

    cond_state_t     state_q, state_d;
    logic [TM_W-1:0] timer_q, timer_d;
    logic            start_q, start_d;
    logic            busy_q, busy_d;
    logic            fault_q, fault_d;

    always_comb begin
        state_d = state_q;
        timer_d = timer_q;
        unique case (state_q)
            IDLE: begin
                if (arm) begin
                    state_d = ARMED;
                    timer_d = '0;
                end
            end
            ARMED: begin
                // Feedback takes priority over an expiring timer.
                if (fb_s) begin
                    state_d = ACTIVE;
                end else if (timer_q == TM_W'(TIMEOUT - 1)) begin
                    state_d = FAULT;
                end else begin
                    timer_d = timer_q + 1'b1;
                end
            end
            ACTIVE:  if (!sensor_q) state_d = RELEASE;
            RELEASE: if (!fb_s)     state_d = IDLE;
            FAULT:   if (fault_clr) state_d = IDLE;
            default: state_d = IDLE;
        endcase
        start_d = (state_d == ARMED) || (state_d == ACTIVE);
        busy_d  = (state_d != IDLE);
        fault_d = (state_d == FAULT);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            timer_q <= '0;
            start_q <= 1'b0;
            busy_q  <= 1'b0;
            fault_q <= 1'b0;
        end else begin
            state_q <= state_d;
            timer_q <= timer_d;
            start_q <= start_d;
            busy_q  <= busy_d;
            fault_q <= fault_d;
        end
    end

    assign filt.start  = start_q;
    assign filt.sensor = sensor_q;
    assign busy        = busy_q;
    assign fault       = fault_q;
    assign glitch_cnt  = glitch_q;

endmodule

// File: tb/tb_sensor_conditioner.sv
// Directed bench for sensor_conditioner with DEBOUNCE=4, TIMEOUT=16, GCNT_W=4.
module tb_sensor_conditioner;

    logic       clk;
    logic       rst_n;
    logic       raw_sensor;
    logic       arm;
    logic       fault_clr;
    logic       busy;
    logic       fault;
    logic [3:0] glitch_cnt;

    sensor_conditioner_if fif ();

    sensor_conditioner #(
        .DEBOUNCE (4),
        .TIMEOUT  (16),
        .GCNT_W   (4)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .raw_sensor (raw_sensor),
        .arm        (arm),
        .fault_clr  (fault_clr),
        .filt       (fif.master),
        .busy       (busy),
        .fault      (fault),
        .glitch_cnt (glitch_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic raw;
        logic arm;
        logic clr;
        logic fb;
        logic exp_sensor;
        logic exp_start;
        logic exp_busy;
        logic exp_fault;
    } vec_t;

    vec_t vecs[$];
    int   checks;
    int   errors;

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Advance one clock; outputs are then sampled 1 ns after the edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic add(input logic r, input logic a, input logic c, input logic f,
                       input logic s, input logic st, input logic b, input logic flt);
        vecs.push_back('{r, a, c, f, s, st, b, flt});
    endtask

    initial begin
        checks     = 0;
        errors     = 0;
        rst_n      = 1'b0;
        raw_sensor = 1'b0;
        arm        = 1'b0;
        fault_clr  = 1'b0;
        fif.actuator_fb = 1'b0;

        // Rising raw edge, then a full arm/active/release cycle.
        for (int i = 0; i < 5; i++) add(1, 0, 0, 0, 0, 0, 0, 0);
        for (int i = 0; i < 5; i++) add(1, 0, 0, 0, 1, 0, 0, 0);
        add(1, 1, 0, 0, 1, 1, 1, 0);
        add(1, 0, 0, 0, 1, 1, 1, 0);
        add(1, 0, 1, 0, 1, 1, 1, 0);
        add(1, 1, 0, 0, 1, 1, 1, 0);
        add(1, 0, 0, 0, 1, 1, 1, 0);
        add(1, 0, 0, 1, 1, 1, 1, 0);
        add(1, 0, 0, 1, 1, 1, 1, 0);
        add(1, 0, 0, 1, 1, 1, 1, 0);
        for (int i = 0; i < 5; i++) add(0, 0, 0, 1, 1, 1, 1, 0);
        add(0, 0, 0, 1, 0, 1, 1, 0);
        add(0, 0, 0, 1, 0, 0, 1, 0);
        add(0, 0, 0, 0, 0, 0, 1, 0);
        add(0, 0, 0, 0, 0, 0, 1, 0);
        add(0, 0, 0, 0, 0, 0, 0, 0);

        #12;
        check("reset_start",  {7'd0, fif.start},  8'd0);
        check("reset_sensor", {7'd0, fif.sensor}, 8'd0);
        check("reset_busy",   {7'd0, busy},       8'd0);
        check("reset_fault",  {7'd0, fault},      8'd0);
        check("reset_glitch", {4'd0, glitch_cnt}, 8'd0);
        rst_n = 1'b1;
        step();

        foreach (vecs[i]) begin
            raw_sensor      = vecs[i].raw;
            arm             = vecs[i].arm;
            fault_clr       = vecs[i].clr;
            fif.actuator_fb = vecs[i].fb;
            step();
            check($sformatf("vec%0d_sensor", i), {7'd0, fif.sensor}, {7'd0, vecs[i].exp_sensor});
            check($sformatf("vec%0d_start", i),  {7'd0, fif.start},  {7'd0, vecs[i].exp_start});
            check($sformatf("vec%0d_busy", i),   {7'd0, busy},       {7'd0, vecs[i].exp_busy});
            check($sformatf("vec%0d_fault", i),  {7'd0, fault},      {7'd0, vecs[i].exp_fault});
            check($sformatf("vec%0d_glitch", i), {4'd0, glitch_cnt}, 8'd0);
        end
        arm       = 1'b0;
        fault_clr = 1'b0;

        // Short pulses are rejected and counted, saturating at 15.
        for (int p = 1; p <= 20; p++) begin
            raw_sensor = 1'b1;
            repeat (3) step();
            raw_sensor = 1'b0;
            repeat (5) step();
            check($sformatf("glitch_p%0d", p), {4'd0, glitch_cnt}, (p > 15) ? 8'd15 : 8'(p));
            check($sformatf("glitch_sensor_p%0d", p), {7'd0, fif.sensor}, 8'd0);
        end

        // No feedback: fault exactly 16 cycles after entering ARMED.
        arm = 1'b1;
        step();
        arm = 1'b0;
        check("to_armed_start", {7'd0, fif.start}, 8'd1);
        repeat (15) step();
        check("to_pre_fault",   {7'd0, fault},     8'd0);
        check("to_pre_start",   {7'd0, fif.start}, 8'd1);
        step();
        check("to_fault",       {7'd0, fault},     8'd1);
        check("to_fault_start", {7'd0, fif.start}, 8'd0);
        check("to_fault_busy",  {7'd0, busy},      8'd1);
        arm = 1'b1;
        step();
        arm = 1'b0;
        check("to_arm_ignored", {7'd0, fault},     8'd1);
        fault_clr = 1'b1;
        step();
        fault_clr = 1'b0;
        check("to_clr_fault",   {7'd0, fault},     8'd0);
        check("to_clr_busy",    {7'd0, busy},      8'd0);

        // Feedback arriving on the last timer cycle wins over the timeout.
        arm = 1'b1;
        step();
        arm = 1'b0;
        repeat (13) step();
        fif.actuator_fb = 1'b1;
        step();
        step();
        check("edge_armed_fault", {7'd0, fault},     8'd0);
        check("edge_armed_start", {7'd0, fif.start}, 8'd1);
        step();
        check("edge_active_start", {7'd0, fif.start}, 8'd1);
        check("edge_active_fault", {7'd0, fault},     8'd0);
        check("edge_active_busy",  {7'd0, busy},      8'd1);
        fif.actuator_fb = 1'b0;
        repeat (4) step();
        check("edge_idle_busy",  {7'd0, busy},  8'd0);
        check("edge_idle_fault", {7'd0, fault}, 8'd0);

        // Asynchronous reset while ACTIVE.
        raw_sensor = 1'b1;
        repeat (6) step();
        check("rst_sensor_hi", {7'd0, fif.sensor}, 8'd1);
        arm = 1'b1;
        step();
        arm = 1'b0;
        fif.actuator_fb = 1'b1;
        repeat (3) step();
        check("rst_active_start", {7'd0, fif.start}, 8'd1);
        #2;
        rst_n = 1'b0;
        #1;
        check("rst_async_start",  {7'd0, fif.start},  8'd0);
        check("rst_async_busy",   {7'd0, busy},       8'd0);
        check("rst_async_sensor", {7'd0, fif.sensor}, 8'd0);
        check("rst_async_glitch", {4'd0, glitch_cnt}, 8'd0);
        raw_sensor      = 1'b0;
        fif.actuator_fb = 1'b0;
        step();
        #2;
        rst_n = 1'b1;
        step();
        check("rst_idle_busy", {7'd0, busy}, 8'd0);
        arm = 1'b1;
        step();
        arm = 1'b0;
        check("rst_rearm_busy",  {7'd0, busy},      8'd1);
        check("rst_rearm_start", {7'd0, fif.start}, 8'd1);
        check("rst_rearm_fault", {7'd0, fault},     8'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
